// File: rtl/alu_self_test.sv
// Built-in self-test engine for the 6-bit ALU. It sweeps all eight function codes with
// LFSR operand pairs, checks X against a golden model, and keeps the first failing vector.
module alu_self_test #(
    parameter int          VECTORS_PER_FXN = 16,
    parameter logic [11:0] SEED            = 12'hACE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [5:0] A,
    output logic [5:0] B,
    output logic [2:0] fxn,
    input  logic [5:0] X,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] fail_fxn,
    output logic [5:0] fail_A,
    output logic [5:0] fail_B,
    output logic [5:0] fail_X
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [11:0] SEED_EFF = (SEED == 12'd0) ? 12'h001 : SEED;
    localparam logic [7:0]  LAST_IDX = 8'(VECTORS_PER_FXN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [11:0] lfsr;
    logic [11:0] lfsr_next;
    logic [7:0]  vec_idx;
    logic [5:0]  golden;
    logic        launch;
    logic        check_en;
    logic        last_idx;
    logic        last_vec;
    logic        mismatch;

    assign launch    = start && ((state == S_IDLE) || (state == S_DONE));
    assign check_en  = (state == S_CHECK);
    assign last_idx  = (vec_idx == LAST_IDX);
    assign last_vec  = last_idx && (fxn == 3'd7);
    assign lfsr_next = {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
    assign mismatch  = (X != golden);

    assign busy = (state == S_DRIVE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 8'd0);

    always_comb begin
        golden = 6'd0;
        case (fxn)
            3'd0: golden = A;
            3'd1: golden = B;
            3'd2: golden = -A;
            3'd3: golden = -B;
            3'd4: golden = ($signed(A) < $signed(B)) ? 6'h3F : 6'h00;
            3'd5: golden = ~(A ^ B);
            3'd6: golden = A + B;
            3'd7: golden = A - B;
            default: golden = 6'd0;
        endcase
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together from pre-edge values, matching the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_DRIVE;
            S_DRIVE: state_next = S_CHECK;
            S_CHECK: state_next = last_vec ? S_DONE : S_DRIVE;
            S_DONE:  if (start) state_next = S_DRIVE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= 12'd0;
            A         <= 6'd0;
            B         <= 6'd0;
            fxn       <= 3'd0;
            vec_idx   <= 8'd0;
            err_count <= 8'd0;
            fail_fxn  <= 3'd0;
            fail_A    <= 6'd0;
            fail_B    <= 6'd0;
            fail_X    <= 6'd0;
        end else if (launch) begin
            lfsr      <= SEED_EFF;
            A         <= SEED_EFF[11:6];
            B         <= SEED_EFF[5:0];
            fxn       <= 3'd0;
            vec_idx   <= 8'd0;
            err_count <= 8'd0;
            fail_fxn  <= 3'd0;
            fail_A    <= 6'd0;
            fail_B    <= 6'd0;
            fail_X    <= 6'd0;
        end else if (check_en) begin
            if (mismatch) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                // A zero count means this is the first mismatch of the run.
                if (err_count == 8'd0) begin
                    fail_fxn <= fxn;
                    fail_A   <= A;
                    fail_B   <= B;
                    fail_X   <= X;
                end
            end
            // The final vector's operands and function stay visible in DONE.
            if (!last_vec) begin
                lfsr    <= lfsr_next;
                A       <= lfsr_next[11:6];
                B       <= lfsr_next[5:0];
                vec_idx <= last_idx ? 8'd0 : vec_idx + 8'd1;
                if (last_idx) fxn <= fxn + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_self_test.sv
// Testbench for alu_self_test: a behavioural ALU (with selectable faults) feeds two
// instances, and a vector-level reference model predicts each run's results.
module tb_alu_self_test;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start0, start1;
    int   mode;
    bit   big;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [5:0] a0, b0, x0, fa0, fb0, fx0, a1, b1, x1, fa1, fb1, fx1;
    logic [2:0] f0, ff0, f1, ff1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] err0, err1;

    alu_self_test dut (
        .clk(clk), .reset(reset), .start(start0), .A(a0), .B(b0), .fxn(f0), .X(x0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_fxn(ff0), .fail_A(fa0), .fail_B(fb0), .fail_X(fx0)
    );

    alu_self_test #(.VECTORS_PER_FXN(40)) dut40 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1), .fxn(f1), .X(x1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_fxn(ff1), .fail_A(fa1), .fail_B(fb1), .fail_X(fx1)
    );

    function automatic logic [5:0] gold(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
        int sa, sb;
        sa = (a >= 6'd32) ? int'(a) - 64 : int'(a);
        sb = (b >= 6'd32) ? int'(b) - 64 : int'(b);
        case (f)
            3'd0: return a;
            3'd1: return b;
            3'd2: return 6'((64 - int'(a)) % 64);
            3'd3: return 6'((64 - int'(b)) % 64);
            3'd4: return (sa < sb) ? 6'd63 : 6'd0;
            3'd5: return ~(a ^ b);
            3'd6: return 6'((int'(a) + int'(b)) % 64);
            default: return 6'((int'(a) - int'(b) + 64) % 64);
        endcase
    endfunction

    // Mode 0 correct, 1 bit-0 flip on add, 2 inverted result, 3 unsigned compare.
    function automatic logic [5:0] alu_model(input int m, input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
        logic [5:0] g;
        g = gold(a, b, f);
        case (m)
            1: return (f == 3'd6) ? (g ^ 6'd1) : g;
            2: return ~g;
            3: return (f == 3'd4) ? ((a < b) ? 6'd63 : 6'd0) : g;
            default: return g;
        endcase
    endfunction

    always_comb x0 = alu_model(mode, a0, b0, f0);
    always_comb x1 = alu_model(mode, a1, b1, f1);

    logic [5:0] s_a, s_b, s_fa, s_fb, s_fx;
    logic [2:0] s_f, s_ff;
    logic       s_busy, s_done, s_pass;
    logic [7:0] s_err;
    always_comb begin
        s_a = big ? a1 : a0;       s_b = big ? b1 : b0;       s_f = big ? f1 : f0;
        s_busy = big ? busy1 : busy0;  s_done = big ? done1 : done0;  s_pass = big ? pass1 : pass0;
        s_err = big ? err1 : err0;     s_ff = big ? ff1 : ff0;
        s_fa = big ? fa1 : fa0;    s_fb = big ? fb1 : fb0;    s_fx = big ? fx1 : fx0;
    end

    // Reference: walk the whole vector sequence and tally what the engine must report.
    task automatic compute_expected(input int m, input int n, output int raw, output int errs,
                                    output logic [2:0] ef, output logic [5:0] ea, output logic [5:0] eb,
                                    output logic [5:0] ex);
        logic [11:0] q;
        logic [5:0]  a, b, x;
        q = 12'hACE; raw = 0; ef = 0; ea = 0; eb = 0; ex = 0;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < n; i++) begin
                a = q[11:6]; b = q[5:0];
                x = alu_model(m, a, b, 3'(f));
                if (x !== gold(a, b, 3'(f))) begin
                    raw++;
                    if (raw == 1) begin ef = 3'(f); ea = a; eb = b; ex = x; end
                end
                q = {q[10:0], q[11] ^ q[10] ^ q[9] ^ q[3]};
            end
        end
        errs = (raw > 255) ? 255 : raw;
    endtask

    task automatic run_test(input string name, input int m, input bit b40, input bit hazard);
        int n, e, raw, errs;
        logic [2:0] ef;
        logic [5:0] ea, eb, ex;
        n = b40 ? 40 : 16;
        mode = m; big = b40;
        compute_expected(m, n, raw, errs, ef, ea, eb, ex);
        @(negedge clk);
        if (b40) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        n_checks++;
        if ({s_busy, s_done, s_a, s_b, s_f} !== {1'b1, 1'b0, 6'b101011, 6'b001110, 3'b000}) begin
            n_errors++;
            $display("FAIL %s first_vector: got busy=%b done=%b A=%b B=%b fxn=%b, required busy=1 done=0 A=101011 B=001110 fxn=000",
                     name, s_busy, s_done, s_a, s_b, s_f);
        end
        e = 0;
        while (!s_done && e < 20 * n) begin
            @(negedge clk);
            e++;
            if (hazard && e == 49) start0 = 1'b1;
            if (hazard && e == 50) start0 = 1'b0;
        end
        n_checks++;
        if (e != 16 * n || s_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done_timing: done seen after edge %0d busy=%b, required edge %0d busy=0", name, e, s_busy, 16 * n);
        end
        n_checks++;
        if (s_err !== 8'(errs) || s_pass !== (errs == 0)) begin
            n_errors++;
            $display("FAIL %s result: got err_count=%0d pass=%b, required err_count=%0d pass=%b", name, s_err, s_pass, errs, errs == 0);
        end
        n_checks++;
        if ({s_ff, s_fa, s_fb, s_fx} !== {ef, ea, eb, ex}) begin
            n_errors++;
            $display("FAIL %s first_fail: got fxn=%b A=%b B=%b X=%b, required fxn=%b A=%b B=%b X=%b",
                     name, s_ff, s_fa, s_fb, s_fx, ef, ea, eb, ex);
        end
        @(negedge clk);
        n_checks++;
        if (s_done !== 1'b1 || s_err !== 8'(errs) || s_f !== 3'd7) begin
            n_errors++;
            $display("FAIL %s hold: got done=%b err_count=%0d fxn=%b, required done=1 err_count=%0d fxn=111", name, s_done, s_err, s_f, errs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0; big = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a0, b0, f0, busy0, done0, pass0, err0, ff0, fa0, fb0, fx0, busy1, done1, err1} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got A=%b B=%b fxn=%b busy=%b done=%b pass=%b err=%0d, required all 0",
                     a0, b0, f0, busy0, done0, pass0, err0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy0, done0, busy1, done1} !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, required busy=0 done=0", busy0, done0);
        end
    endtask

    task automatic test_clean();
        run_test("clean", 0, 1'b0, 1'b0);
    endtask

    task automatic test_single_fault();
        run_test("single_fault", 1, 1'b0, 1'b0);
        n_checks++;
        if (err0 !== 8'd16 || ff0 !== 3'b110 || fx0 !== (gold(fa0, fb0, 3'd6) ^ 6'd1)) begin
            n_errors++;
            $display("FAIL single_fault_const: got err=%0d fail_fxn=%b fail_X=%b, required err=16 fail_fxn=110 fail_X=golden^1", err0, ff0, fx0);
        end
    endtask

    task automatic test_signed_compare();
        run_test("signed_compare", 3, 1'b0, 1'b0);
        n_checks++;
        if (pass0 !== 1'b0 || ff0 !== 3'b100 || fa0[5] == fb0[5]) begin
            n_errors++;
            $display("FAIL signed_compare_const: got pass=%b fail_fxn=%b A5=%b B5=%b, required pass=0 fail_fxn=100 A5!=B5", pass0, ff0, fa0[5], fb0[5]);
        end
    endtask

    task automatic test_saturation();
        int raw, errs;
        logic [2:0] ef;
        logic [5:0] ea, eb, ex;
        compute_expected(2, 40, raw, errs, ef, ea, eb, ex);
        n_checks++;
        if (raw != 320) begin
            n_errors++;
            $display("FAIL saturation_model: got %0d mismatches, required 320", raw);
        end
        run_test("saturation", 2, 1'b1, 1'b0);
        n_checks++;
        if ({err1, ff1, fa1, fb1, fx1} !== {8'd255, 3'b000, 6'b101011, 6'b001110, 6'b010100}) begin
            n_errors++;
            $display("FAIL saturation_const: got err=%0d fxn=%b A=%b B=%b X=%b, required 255 000 101011 001110 010100",
                     err1, ff1, fa1, fb1, fx1);
        end
        big = 1'b0;
    endtask

    task automatic test_start_ignored();
        run_test("start_ignored", 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midrun();
        int e;
        mode = 1; big = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a0, b0, f0, busy0, done0, pass0, err0, ff0, fa0, fb0, fx0} !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset: got A=%b B=%b fxn=%b busy=%b err=%0d fail_fxn=%b, required all 0", a0, b0, f0, busy0, err0, ff0);
        end
        @(negedge clk);
        reset = 1'b0; start0 = 1'b1; mode = 0;
        @(negedge clk);
        start0 = 1'b0;
        n_checks++;
        if ({busy0, a0, b0, f0} !== {1'b1, 6'b101011, 6'b001110, 3'b000}) begin
            n_errors++;
            $display("FAIL midrun_restart: got busy=%b A=%b B=%b fxn=%b, required busy=1 A=101011 B=001110 fxn=000", busy0, a0, b0, f0);
        end
        e = 0;
        while (!done0 && e < 400) begin
            @(negedge clk);
            e++;
        end
        n_checks++;
        if (e != 256 || pass0 !== 1'b1 || err0 !== 8'd0) begin
            n_errors++;
            $display("FAIL midrun_complete: got done at edge %0d pass=%b err=%0d, required edge 256 pass=1 err=0", e, pass0, err0);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_fault();
        test_signed_compare();
        test_saturation();
        test_start_ignored();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_self_test.md
# alu_self_test

Sequential built-in self-test engine that drives the 6-bit ALU's operand and function inputs and checks its result on the Basys 3 board. It steps through all eight function codes, applies pseudo-random operand pairs from an internal LFSR, and compares X against an internal golden model. It reports pass/fail, a mismatch count and the first failing vector.

## Interface
- VECTORS_PER_FXN, 16: operand pairs applied per function code. Legal range 1..255.
- SEED, 12'hACE: LFSR seed loaded at each test start. A value of 0 is replaced by 12'h001.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and all outputs to 0.
- start  input  1  request to begin a test; sampled in IDLE and DONE only.
- A  output  6  operand A to the ALU (registered).
- B  output  6  operand B to the ALU (registered).
- fxn  output  3  function code to the ALU (registered).
- X  input  6  ALU result (combinational from A, B, fxn).
- busy  output  1  high while a test is in progress.
- done  output  1  high from test completion until the next start or reset.
- pass  output  1  valid while done is high; 1 when err_count is 0.
- err_count  output  8  mismatch count; saturates at 255.
- fail_fxn  output  3  fxn of the first mismatch.
- fail_A  output  6  A of the first mismatch.
- fail_B  output  6  B of the first mismatch.
- fail_X  output  6  X observed at the first mismatch.

## Operation
- Golden model; all arithmetic is modulo 64 with the carry discarded.
  - 000: A.
  - 001: B.
  - 010: −A (two's complement).
  - 011: −B.
  - 100: 6'b111111 if A < B as signed two's complement, else 6'b000000.
  - 101: ~(A ^ B).
  - 110: A + B.
  - 111: A − B.
- LFSR: 12-bit Fibonacci. feedback = q[11]^q[10]^q[9]^q[3]; q <= {q[10:0], feedback}. Maximal length 4095; never all-zero.
- Operand mapping: A = q[11:6], B = q[5:0].
- The LFSR advances once per vector and runs continuously across function codes.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE
  - Outputs: A, B, fxn = 0; busy = 0.
  - On start: clear err_count and all fail_* registers, load SEED, set fxn = 0 and vector index = 0, go to DRIVE.
- DRIVE
  - Present A, B and fxn to the ALU for one settle cycle.
  - Go to CHECK.
- CHECK
  - Sample X and compare it with golden(A, B, fxn).
  - On mismatch: increment err_count (saturating). If this is the first mismatch of the run, capture fail_fxn, fail_A, fail_B and fail_X.
  - Then advance: step the LFSR and increment the index. When the index wraps from VECTORS_PER_FXN−1 to 0, increment fxn.
  - After the last vector of fxn 111, go to DONE; otherwise go to DRIVE.
- DONE
  - busy = 0, done = 1, pass = (err_count == 0).
  - A, B and fxn hold their last values.
  - Results hold until start, which behaves exactly as start in IDLE.
- start while busy is ignored.
- start held high continuously causes an immediate restart on entry to DONE, after one cycle with done = 1.

## Timing
- Reset: all outputs 0 (A, B, fxn, busy, done, pass, err_count, fail_*).
- The edge that samples start (edge 0) enters DRIVE. busy and the first vector appear after edge 0.
- Each vector takes exactly 2 cycles (DRIVE, then CHECK).
- After edge 0, the first vector is A = SEED[11:6], B = SEED[5:0], fxn = 000.
- done and pass become valid after edge 16·VECTORS_PER_FXN; this is edge 256 at the default parameter.
- busy falls on the same edge that done rises.
- err_count is updated on the CHECK edge of the mismatching vector. fail_* registers are written only once per run.
- Reset asserted mid-test: immediate return to IDLE with all outputs 0. Partial results are discarded.
- Reset release: the first start is honoured on the first rising edge with reset low.

## Test plan
- Reset behaviour: assert reset for 3 cycles, then release.
  - Required: all outputs 0; busy = 0 and done = 0 until start.
- Clean run: correct ALU model in the bench, default parameters, one-cycle start pulse.
  - Required: busy high after edge 0; first vector A = 101011, B = 001110, fxn = 000.
  - Required: done = 1 and pass = 1 after edge 256; err_count = 0.
- Single-function fault: bench ALU returns golden^6'b000001 for fxn = 110 only.
  - Required: err_count = 16 and pass = 0.
  - Required: fail_fxn = 110; fail_A and fail_B equal the 97th LFSR vector; fail_X = golden^000001.
- Saturation: VECTORS_PER_FXN = 40, bench ALU returns ~golden for every vector.
  - Required: 320 mismatches; err_count = 255; fail_fxn = 000, fail_A = 101011, fail_B = 001110, fail_X = 010100.
- Signed compare: bench ALU implements an unsigned A < B.
  - Required: pass = 0, fail_fxn = 100, and err_count equals the number of fxn-100 vectors with A[5] ≠ B[5].
- Control hazards:
  - Pulse start at edge 50 of a run. Required: ignored; done still rises after edge 256.
  - Assert reset at edge 100, then start again. Required: immediate IDLE with all outputs 0; the run restarts from A = 101011, B = 001110, fxn = 000.
